// File: rtl/sfence_flush_seq_if.sv
// Handshake bundle between privileged decode, the sfence sequencer and the two
// TLB flush ports. The master modport is the sequencer's side of it.
interface sfence_flush_seq_if #(
  parameter int VA_BITS   = 39,
  parameter int ASID_BITS = 16
);
  logic                 SfenceVmaM;
  logic                 FlushM;
  logic                 Rs1ZeroM;
  logic                 Rs2ZeroM;
  logic [VA_BITS-1:0]   VaddrM;
  logic [ASID_BITS-1:0] AsidM;
  logic                 DTLBFlushAck;
  logic                 ITLBFlushAck;
  logic                 SfenceStallM;
  logic                 DTLBFlushReq;
  logic                 ITLBFlushReq;
  logic [VA_BITS-1:0]   FlushVaddr;
  logic [ASID_BITS-1:0] FlushAsid;
  logic                 FlushAllVaddr;
  logic                 FlushAllAsid;
  logic                 SfenceDoneM;
  logic                 SfenceTimeoutErr;

  modport master (
    input  SfenceVmaM, FlushM, Rs1ZeroM, Rs2ZeroM, VaddrM, AsidM,
    input  DTLBFlushAck, ITLBFlushAck,
    output SfenceStallM, DTLBFlushReq, ITLBFlushReq,
    output FlushVaddr, FlushAsid, FlushAllVaddr, FlushAllAsid,
    output SfenceDoneM, SfenceTimeoutErr
  );

  modport slave (
    output SfenceVmaM, FlushM, Rs1ZeroM, Rs2ZeroM, VaddrM, AsidM,
    output DTLBFlushAck, ITLBFlushAck,
    input  SfenceStallM, DTLBFlushReq, ITLBFlushReq,
    input  FlushVaddr, FlushAsid, FlushAllVaddr, FlushAllAsid,
    input  SfenceDoneM, SfenceTimeoutErr
  );
endinterface

// File: rtl/sfence_flush_seq.sv
// sfence.vma TLB flush sequencer (M stage).
// Stalls the pipe, latches rs1/rs2 operands, flushes the DTLB then the ITLB,
// and releases the stall with a one-cycle done pulse. Each ack wait is bounded
// by ACK_TIMEOUT; an expired wait advances anyway and sets a sticky error.
// Build option: SFENCE_PARALLEL_EN issues both TLB flushes together in a
// single FLUSH state sharing one timeout counter.
module sfence_flush_seq #(
  parameter int VA_BITS     = 39,
  parameter int ASID_BITS   = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  sfence_flush_seq_if.master  flush_if
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

`ifdef SFENCE_PARALLEL_EN
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DFLUSH, S_IFLUSH, S_DONE} state_t;
`endif

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next, w_cnt_inc;
  logic [VA_BITS-1:0]   r_vaddr;
  logic [ASID_BITS-1:0] r_asid;
  logic                 r_all_va, r_all_asid, r_err;
  logic                 w_start, w_expire, w_err_set;
  logic                 w_stall, w_dreq, w_ireq, w_done;
`ifdef SFENCE_PARALLEL_EN
  logic                 r_dpend, r_ipend, w_dpend_next, w_ipend_next;
`endif

  // reset term keeps the combinational stall low while reset is held
  assign w_start   = (r_state == S_IDLE) & flush_if.SfenceVmaM & ~flush_if.FlushM & reset;
  assign w_cnt_inc = r_cnt + 1'b1;
  // the current waiting cycle is the ACK_TIMEOUT-th one
  assign w_expire  = (w_cnt_inc == CNT_W'(ACK_TIMEOUT));

  // state, wait counter and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= r_err | w_err_set;
    end
  end

  // operand latch, loaded only when a sequence starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vaddr    <= '0;
      r_asid     <= '0;
      r_all_va   <= 1'b0;
      r_all_asid <= 1'b0;
    end else if (w_start) begin
      r_vaddr    <= flush_if.VaddrM;
      r_asid     <= flush_if.AsidM;
      r_all_va   <= flush_if.Rs1ZeroM;
      r_all_asid <= flush_if.Rs2ZeroM;
    end
  end

`ifdef SFENCE_PARALLEL_EN
  // outstanding-ack flags for the merged flush state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dpend <= 1'b0;
      r_ipend <= 1'b0;
    end else begin
      r_dpend <= w_dpend_next;
      r_ipend <= w_ipend_next;
    end
  end
`endif

  // next state, counter control and handshake outputs
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_err_set  = 1'b0;
    w_stall    = 1'b0;
    w_dreq     = 1'b0;
    w_ireq     = 1'b0;
    w_done     = 1'b0;
`ifdef SFENCE_PARALLEL_EN
    w_dpend_next = r_dpend;
    w_ipend_next = r_ipend;
`endif
    case (r_state)
      S_IDLE: begin
        w_stall = w_start;
        if (w_start) begin
          w_cnt_next = '0;
`ifdef SFENCE_PARALLEL_EN
          w_next       = S_FLUSH;
          w_dpend_next = 1'b1;
          w_ipend_next = 1'b1;
`else
          w_next = S_DFLUSH;
`endif
        end
      end
`ifdef SFENCE_PARALLEL_EN
      S_FLUSH: begin
        w_stall      = 1'b1;
        w_dreq       = r_dpend;
        w_ireq       = r_ipend;
        w_cnt_next   = w_cnt_inc;
        w_dpend_next = r_dpend & ~flush_if.DTLBFlushAck;
        w_ipend_next = r_ipend & ~flush_if.ITLBFlushAck;
        if (!w_dpend_next && !w_ipend_next) begin
          w_next = S_DONE;
        end else if (w_expire) begin
          // give up on whichever TLB is still silent
          w_next       = S_DONE;
          w_err_set    = 1'b1;
          w_dpend_next = 1'b0;
          w_ipend_next = 1'b0;
        end
      end
`else
      S_DFLUSH: begin
        w_stall    = 1'b1;
        w_dreq     = 1'b1;
        w_cnt_next = w_cnt_inc;
        if (flush_if.DTLBFlushAck || w_expire) begin
          w_next     = S_IFLUSH;
          w_cnt_next = '0;
          w_err_set  = ~flush_if.DTLBFlushAck;
        end
      end
      S_IFLUSH: begin
        w_stall    = 1'b1;
        w_ireq     = 1'b1;
        w_cnt_next = w_cnt_inc;
        if (flush_if.ITLBFlushAck || w_expire) begin
          w_next     = S_DONE;
          w_cnt_next = '0;
          w_err_set  = ~flush_if.ITLBFlushAck;
        end
      end
`endif
      S_DONE: begin
        // instruction leaves M this cycle; no new request is taken here
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign flush_if.SfenceStallM     = w_stall;
  assign flush_if.DTLBFlushReq     = w_dreq;
  assign flush_if.ITLBFlushReq     = w_ireq;
  assign flush_if.SfenceDoneM      = w_done;
  assign flush_if.SfenceTimeoutErr = r_err;
  assign flush_if.FlushVaddr       = r_vaddr;
  assign flush_if.FlushAsid        = r_asid;
  assign flush_if.FlushAllVaddr    = r_all_va;
  assign flush_if.FlushAllAsid     = r_all_asid;

endmodule

// File: tb/tb_sfence_flush_seq.sv
// Randomized scoreboard bench for sfence_flush_seq (ACK_TIMEOUT=4).
// A driver issues sequences with chosen ack delays and pushes the expected
// sequence summary; a monitor measures each sequence and compares at done.
module tb_sfence_flush_seq;
  localparam int VA = 39;
  localparam int AS = 16;
  localparam int TO = 4;
  localparam int NEVER = 1000;

  typedef struct {
    logic [VA-1:0] va;
    logic [AS-1:0] asid;
    logic          av;
    logic          aa;
    int            dc;   // cycles DTLBFlushReq high
    int            ic;   // cycles ITLBFlushReq high
    int            sc;   // cycles stall high
    logic          err;  // sticky error after this sequence
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfence_flush_seq_if #(.VA_BITS(VA), .ASID_BITS(AS)) ifc();

  sfence_flush_seq #(.VA_BITS(VA), .ASID_BITS(AS), .ACK_TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .flush_if (ifc)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   cur_dd = 0;
  int   cur_id = 0;
  bit   stray_en = 1'b0;
  logic model_err = 1'b0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 64'(ifc.SfenceStallM), 0);
    chk({tag, "_dreq"},  64'(ifc.DTLBFlushReq), 0);
    chk({tag, "_ireq"},  64'(ifc.ITLBFlushReq), 0);
    chk({tag, "_done"},  64'(ifc.SfenceDoneM), 0);
    chk({tag, "_err"},   64'(ifc.SfenceTimeoutErr), 0);
    chk({tag, "_va"},    64'(ifc.FlushVaddr), 0);
    chk({tag, "_asid"},  64'(ifc.FlushAsid), 0);
    chk({tag, "_allva"}, 64'(ifc.FlushAllVaddr), 0);
    chk({tag, "_allas"}, 64'(ifc.FlushAllAsid), 0);
  endtask

  // random garbage on every input the busy sequencer must ignore
  task automatic scramble(input bit force_flush);
    ifc.SfenceVmaM = 1'($urandom_range(0, 1));
    ifc.FlushM     = force_flush ? 1'b1 : 1'($urandom_range(0, 1));
    ifc.VaddrM     = VA'({$urandom(), $urandom()});
    ifc.AsidM      = AS'($urandom());
    ifc.Rs1ZeroM   = 1'($urandom_range(0, 1));
    ifc.Rs2ZeroM   = 1'($urandom_range(0, 1));
  endtask

  // reference: sequence shape from the ack delays (cycles after the Req rises)
  task automatic issue(input logic [VA-1:0] va, input logic [AS-1:0] asid,
                       input logic av, input logic aa, input int dd, input int id);
    exp_t e;
    bit   to;
    int   span;
    e.va = va; e.asid = asid; e.av = av; e.aa = aa;
    e.dc = imin(dd + 1, TO);
    e.ic = imin(id + 1, TO);
`ifdef SFENCE_PARALLEL_EN
    span = ((dd > id) ? dd : id) + 1;
    to   = (span > TO);
    e.sc = 1 + imin(span, TO);
`else
    span = 0;
    to   = (dd >= TO) || (id >= TO);
    e.sc = 1 + e.dc + e.ic + span;
`endif
    model_err = model_err | to;
    e.err = model_err;
    sb.push_back(e);
    cur_dd = dd;
    cur_id = id;
    @(posedge clk); #1;
    ifc.SfenceVmaM = 1'b1;
    ifc.FlushM     = 1'b0;
    ifc.VaddrM     = va;
    ifc.AsidM      = asid;
    ifc.Rs1ZeroM   = av;
    ifc.Rs2ZeroM   = aa;
  endtask

  task automatic wait_done(input bit force_flush);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk); #1;
      if (ifc.SfenceDoneM) begin
        seen = 1'b1;
        ifc.FlushM     = 1'b0;
        ifc.SfenceVmaM = 1'($urandom_range(0, 1));  // must not start in DONE
      end else begin
        scramble(force_flush);
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: got no SfenceDoneM required one within 60 cycles");
    end
    @(posedge clk); #1;
    ifc.SfenceVmaM = 1'b0;
  endtask

  task automatic run_seq(input logic [VA-1:0] va, input logic [AS-1:0] asid,
                         input logic av, input logic aa, input int dd, input int id,
                         input bit force_flush);
    stray_en = 1'($urandom_range(0, 1));
    issue(va, asid, av, aa, dd, id);
    wait_done(force_flush);
  endtask

  // idle cycles, sometimes with a killed sfence that must not start
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ifc.SfenceVmaM = 1'($urandom_range(0, 1));
      ifc.FlushM     = ifc.SfenceVmaM ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("idle_stall", 64'(ifc.SfenceStallM), 0);
      chk("idle_dreq",  64'(ifc.DTLBFlushReq), 0);
    end
    @(posedge clk); #1;
    ifc.SfenceVmaM = 1'b0;
    ifc.FlushM     = 1'b0;
  endtask

  // DTLB responder: ack cur_dd cycles after the Req rises, stray acks otherwise
  initial begin
    int seen = 0;
    ifc.DTLBFlushAck = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ifc.DTLBFlushReq) begin
        ifc.DTLBFlushAck = (seen == cur_dd);
        seen++;
      end else begin
        seen = 0;
        ifc.DTLBFlushAck = stray_en && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // ITLB responder
  initial begin
    int seen = 0;
    ifc.ITLBFlushAck = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ifc.ITLBFlushReq) begin
        ifc.ITLBFlushAck = (seen == cur_id);
        seen++;
      end else begin
        seen = 0;
        ifc.ITLBFlushAck = stray_en && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // monitor: measure each sequence, compare at the done pulse
  initial begin
    int   dcnt = 0;
    int   icnt = 0;
    int   scnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dcnt = 0; icnt = 0; scnt = 0;
      end else if (sb.size() == 0) begin
        chk("spurious_activity",
            64'({ifc.SfenceStallM, ifc.DTLBFlushReq, ifc.ITLBFlushReq, ifc.SfenceDoneM}), 0);
      end else if (ifc.SfenceDoneM) begin
        e = sb.pop_front();
        chk("done_stall", 64'(ifc.SfenceStallM), 0);
        chk("dreq_cycles", 64'(dcnt), 64'(e.dc));
        chk("ireq_cycles", 64'(icnt), 64'(e.ic));
        chk("stall_cycles", 64'(scnt), 64'(e.sc));
        chk("timeout_err", 64'(ifc.SfenceTimeoutErr), 64'(e.err));
        chk("done_va", 64'(ifc.FlushVaddr), 64'(e.va));
        chk("done_asid", 64'(ifc.FlushAsid), 64'(e.asid));
        dcnt = 0; icnt = 0; scnt = 0;
      end else begin
        if (ifc.DTLBFlushReq) dcnt++;
        if (ifc.ITLBFlushReq) icnt++;
        if (ifc.SfenceStallM) scnt++;
`ifndef SFENCE_PARALLEL_EN
        if (ifc.DTLBFlushReq && ifc.ITLBFlushReq) chk("req_overlap", 1, 0);
        if (ifc.DTLBFlushReq && icnt != 0) chk("d_after_i", 64'(icnt), 0);
`endif
        if (ifc.DTLBFlushReq || ifc.ITLBFlushReq) begin
          chk("req_va", 64'(ifc.FlushVaddr), 64'(sb[0].va));
          chk("req_asid", 64'(ifc.FlushAsid), 64'(sb[0].asid));
          chk("req_allva", 64'(ifc.FlushAllVaddr), 64'(sb[0].av));
          chk("req_allasid", 64'(ifc.FlushAllAsid), 64'(sb[0].aa));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  // main stimulus
  initial begin
    bit found;
    ifc.SfenceVmaM = 1'b1;  // a live request during reset must not stall
    ifc.FlushM     = 1'b0;
    ifc.Rs1ZeroM   = 1'b1;
    ifc.Rs2ZeroM   = 1'b1;
    ifc.VaddrM     = '1;
    ifc.AsidM      = '1;
    #12;
    chk_zero("reset");
    ifc.SfenceVmaM = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;

    idle(4);
    run_seq(39'h12345000, 16'h7, 1'b0, 1'b0, 1, 1, 1'b0);
    run_seq(39'h7f_0000_1000, 16'hbeef, 1'b1, 1'b0, TO - 1, TO - 1, 1'b0);  // ack on expiry cycle
    run_seq(39'h0_0badc_0de0, 16'h1, 1'b0, 1'b1, 2, 0, 1'b1);              // flush during sequence
    run_seq(39'h40_0000_0000, 16'h22, 1'b0, 1'b0, NEVER, 1, 1'b0);         // DTLB never acks
    run_seq(39'h1_2222_3000, 16'h33, 1'b1, 1'b1, 0, 0, 1'b0);              // error stays sticky
    run_seq(39'h2_0000_0000, 16'h44, 1'b0, 1'b0, 0, NEVER, 1'b0);

    // reset while the ITLB flush is outstanding
    stray_en = 1'b0;
    issue(39'h3_3333_3000, 16'h55, 1'b0, 1'b0, 0, NEVER);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge clk); #1;
      if (ifc.ITLBFlushReq) found = 1'b1;
      else scramble(1'b0);
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL iflush_wait: got no ITLBFlushReq required one within 20 cycles");
    end
    #2;
    ifc.SfenceVmaM = 1'b1;
    ifc.FlushM     = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    if (sb.size() > 0) void'(sb.pop_front());
    model_err = 1'b0;
    ifc.SfenceVmaM = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    run_seq(39'h5_5555_5000, 16'h66, 1'b0, 1'b0, 1, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int dd, id;
      dd = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      id = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      idle(int'($urandom_range(0, 2)));
      run_seq(VA'({$urandom(), $urandom()}), AS'($urandom()),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              dd, id, 1'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sfence_flush_seq.md
Name: sfence_flush_seq

Overview:
- Sequences the TLB invalidation side effects of a decoded sfence.vma (or any svinval instruction treated as sfence.vma) in the M stage.
- On a request it stalls the pipeline and latches the operands. It then issues ordered flush handshakes to the DTLB and then the ITLB, and releases the stall with a one-cycle done pulse.
- Sits between privileged decode and the two MMUs, and is the only block that drives TLB flush requests.

Parameters:
- VA_BITS, 39, width of virtual address operand latched from rs1
- ASID_BITS, 16, width of ASID operand latched from rs2
- ACK_TIMEOUT, 255, max cycles waiting for one ack before forced advance (1..65535)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- SfenceVmaM  input  1  sfence.vma/svinval decoded and legal in M stage (level)
- FlushM  input  1  M-stage instruction is being flushed
- Rs1ZeroM  input  1  rs1 field == x0 (all addresses)
- Rs2ZeroM  input  1  rs2 field == x0 (all ASIDs)
- VaddrM  input  VA_BITS  rs1 value
- AsidM  input  ASID_BITS  rs2 value
- DTLBFlushAck  input  1  single-cycle ack from DTLB
- ITLBFlushAck  input  1  single-cycle ack from ITLB
- SfenceStallM  output  1  hold M stage and earlier
- DTLBFlushReq  output  1  DTLB flush request (level)
- ITLBFlushReq  output  1  ITLB flush request (level)
- FlushVaddr  output  VA_BITS  latched address
- FlushAsid  output  ASID_BITS  latched ASID
- FlushAllVaddr  output  1  latched Rs1ZeroM
- FlushAllAsid  output  1  latched Rs2ZeroM
- SfenceDoneM  output  1  one-cycle completion pulse
- SfenceTimeoutErr  output  1  sticky: an ack timed out

Behaviour:
- Reset (reset==0, async): state IDLE; every output 0; latched operands 0; counter 0; error flag cleared. Reset mid-sequence abandons the sequence; Req lines drop immediately.
- States: IDLE, DFLUSH, IFLUSH, DONE.
- IDLE:
  - SfenceVmaM & ~FlushM → latch VaddrM, AsidM, Rs1ZeroM, Rs2ZeroM; go to DFLUSH.
  - SfenceStallM = SfenceVmaM & ~FlushM, combinational in the same cycle so the instruction cannot leave M.
  - SfenceVmaM & FlushM → no start, no stall.
- DFLUSH: DTLBFlushReq=1, stall=1. On DTLBFlushAck go to IFLUSH the next cycle; Req drops in that cycle.
- IFLUSH: ITLBFlushReq=1, stall=1. On ITLBFlushAck go to DONE.
- DONE:
  - SfenceDoneM=1 and SfenceStallM=0 for exactly one cycle, then IDLE.
  - A new request is not accepted in DONE. The instruction advances out of M on the DONE cycle, so SfenceVmaM seen in the following IDLE cycle belongs to the next instruction.
- Latency with zero-wait acks (ack in the first Req cycle): request cycle T; DFLUSH T+1; IFLUSH T+2; DONE T+3. Stall is high T..T+2.
- Once out of IDLE, FlushM and SfenceVmaM are ignored; the sequence always completes.
- Operand outputs hold their latched values from the start of the sequence until the next start. They are stable whenever a Req is high.
- Acks arriving in a state that does not expect them are ignored.
- Timeout:
  - Counter of width clog2(ACK_TIMEOUT+1) clears on entry to DFLUSH/IFLUSH and increments each waiting cycle.
  - When the count reaches ACK_TIMEOUT without an ack, advance as if acked and set SfenceTimeoutErr. The flag stays set until reset.
  - An ack on the exact timeout cycle counts as a normal ack; no error.

Optional Feature:
- SFENCE_PARALLEL_EN defined:
  - DFLUSH and IFLUSH merge into one FLUSH state with both Req lines high.
  - Each Req drops individually in the cycle after its own ack. Acks may arrive in any order or in the same cycle.
  - DONE follows the cycle after both acks have been seen.
  - Single shared timeout counter; on expiry both outstanding Reqs drop and the error flag is set.
  - Zero-wait latency becomes T..T+2 with DONE at T+2.
- Undefined: sequential D-then-I ordering as above.

Test Plan:
- Basic sequencing:
  - Stimulus: reset released; SfenceVmaM=1, VaddrM=0x12345000, AsidM=0x7, Rs1ZeroM=0, Rs2ZeroM=0; acks return one cycle after each Req.
  - Required response: DTLBFlushReq high for 2 cycles, then ITLBFlushReq high for 2 cycles; FlushVaddr=0x12345000 and FlushAsid=7 throughout; SfenceDoneM pulses once; stall high exactly 5 cycles.
- Flush in IDLE:
  - Stimulus: SfenceVmaM=1 with FlushM=1.
  - Required response: no Req, SfenceStallM=0, state stays IDLE.
- Flush mid-sequence:
  - Stimulus: FlushM=1 asserted during DFLUSH.
  - Required response: sequence completes unchanged; SfenceDoneM still pulses.
- Timeout:
  - Stimulus: ACK_TIMEOUT=4; DTLB never acks.
  - Required response: DTLBFlushReq high 4 cycles, then IFLUSH is entered and SfenceTimeoutErr=1 stays set; a later clean sequence leaves it at 1.
- Reset mid-sequence:
  - Stimulus: reset asserted low during IFLUSH.
  - Required response: all outputs 0 immediately, without waiting for a clock edge; after release, a new request starts from DFLUSH.
- With SFENCE_PARALLEL_EN:
  - Stimulus: ITLB acks at T+1, DTLB acks at T+3.
  - Required response: both Reqs high at T+1; ITLBFlushReq low at T+2; DTLBFlushReq low at T+4; SfenceDoneM at T+4.
